// File: rtl/dist_pkg.sv
// Shared definitions for the distance sorter: candidate count, default
// widths and the FSM state type.
package dist_pkg;

    localparam int NUM_CAND      = 4;
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_IDX_WIDTH = 2;

    // Legacy state encodings, kept so existing decoders still match.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SORT = ST_SORT,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/dist_cmp_swap.sv
// Combinational compare-exchange cell.
// Ports:
//   distA/idxA  upper-slot entry (should end up as the smaller)
//   distB/idxB  lower-slot entry
//   loDist/loIdx, hiDist/hiIdx  ordered pair, lo <= hi
// Swaps only when distB < distA, so equal distances keep their order.
module dist_cmp_swap #(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = 2
) (
    input  logic [WIDTH-1:0]     distA,
    input  logic [IDX_WIDTH-1:0] idxA,
    input  logic [WIDTH-1:0]     distB,
    input  logic [IDX_WIDTH-1:0] idxB,
    output logic [WIDTH-1:0]     loDist,
    output logic [IDX_WIDTH-1:0] loIdx,
    output logic [WIDTH-1:0]     hiDist,
    output logic [IDX_WIDTH-1:0] hiIdx
);

    logic swap;

    assign swap   = (distB < distA);
    assign loDist = swap ? distB : distA;
    assign loIdx  = swap ? idxB  : idxA;
    assign hiDist = swap ? distA : distB;
    assign hiIdx  = swap ? idxA  : idxB;

endmodule

// File: rtl/dist_sorter.sv
// Four-candidate distance sorter using a sequential odd-even transposition
// network (one phase per cycle, four phases).
// Ports:
//   clk, rst (async, active-low)
//   inaDist..indDist, inValid, inReady   input set handshake
//   out0Dist..out3Dist, out0Idx..out3Idx sorted result (out0 = minimum)
//   outValid, outReady                   result handshake
module dist_sorter
    import dist_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     inaDist,
    input  logic [WIDTH-1:0]     inbDist,
    input  logic [WIDTH-1:0]     incDist,
    input  logic [WIDTH-1:0]     indDist,
    input  logic                 inValid,
    output logic                 inReady,
    output logic [WIDTH-1:0]     out0Dist,
    output logic [WIDTH-1:0]     out1Dist,
    output logic [WIDTH-1:0]     out2Dist,
    output logic [WIDTH-1:0]     out3Dist,
    output logic [IDX_WIDTH-1:0] out0Idx,
    output logic [IDX_WIDTH-1:0] out1Idx,
    output logic [IDX_WIDTH-1:0] out2Idx,
    output logic [IDX_WIDTH-1:0] out3Idx,
    output logic                 outValid,
    input  logic                 outReady
);

    state_t               state;
    logic [1:0]           phase;
    logic [WIDTH-1:0]     wDist [NUM_CAND];
    logic [IDX_WIDTH-1:0] wIdx  [NUM_CAND];
    logic [WIDTH-1:0]     nDist [NUM_CAND];
    logic [IDX_WIDTH-1:0] nIdx  [NUM_CAND];
    logic [WIDTH-1:0]     oDist [NUM_CAND];
    logic [IDX_WIDTH-1:0] oIdx  [NUM_CAND];

    logic [WIDTH-1:0]     c0ADist, c0BDist, c0LoDist, c0HiDist;
    logic [IDX_WIDTH-1:0] c0AIdx,  c0BIdx,  c0LoIdx,  c0HiIdx;
    logic [WIDTH-1:0]     c1LoDist, c1HiDist;
    logic [IDX_WIDTH-1:0] c1LoIdx,  c1HiIdx;

    // Cell 0 is shared: pair (0,1) on even phases, pair (1,2) on odd phases.
    assign c0ADist = phase[0] ? wDist[1] : wDist[0];
    assign c0AIdx  = phase[0] ? wIdx[1]  : wIdx[0];
    assign c0BDist = phase[0] ? wDist[2] : wDist[1];
    assign c0BIdx  = phase[0] ? wIdx[2]  : wIdx[1];

    dist_cmp_swap #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) uCmp0 (
        .distA (c0ADist), .idxA (c0AIdx),
        .distB (c0BDist), .idxB (c0BIdx),
        .loDist(c0LoDist), .loIdx(c0LoIdx),
        .hiDist(c0HiDist), .hiIdx(c0HiIdx)
    );

    // Cell 1 always looks at pair (2,3); its result is used on even phases only.
    dist_cmp_swap #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) uCmp1 (
        .distA (wDist[2]), .idxA (wIdx[2]),
        .distB (wDist[3]), .idxB (wIdx[3]),
        .loDist(c1LoDist), .loIdx(c1LoIdx),
        .hiDist(c1HiDist), .hiIdx(c1HiIdx)
    );

    always_comb begin
        nDist = wDist;
        nIdx  = wIdx;
        if (!phase[0]) begin
            nDist[0] = c0LoDist; nIdx[0] = c0LoIdx;
            nDist[1] = c0HiDist; nIdx[1] = c0HiIdx;
            nDist[2] = c1LoDist; nIdx[2] = c1LoIdx;
            nDist[3] = c1HiDist; nIdx[3] = c1HiIdx;
        end else begin
            nDist[1] = c0LoDist; nIdx[1] = c0LoIdx;
            nDist[2] = c0HiDist; nIdx[2] = c0HiIdx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            phase <= '0;
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                wDist[i] <= '0;
                wIdx[i]  <= '0;
                oDist[i] <= '0;
                oIdx[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        wDist[0] <= inaDist;
                        wDist[1] <= inbDist;
                        wDist[2] <= incDist;
                        wDist[3] <= indDist;
                        for (int unsigned i = 0; i < NUM_CAND; i++)
                            wIdx[i] <= IDX_WIDTH'(i);
                        phase <= '0;
                        state <= SORT;
                    end
                end
                SORT: begin
                    wDist <= nDist;
                    wIdx  <= nIdx;
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        // Capture the result of the final phase directly.
                        oDist <= nDist;
                        oIdx  <= nIdx;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (outReady)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);

    assign out0Dist = oDist[0];
    assign out1Dist = oDist[1];
    assign out2Dist = oDist[2];
    assign out3Dist = oDist[3];
    assign out0Idx  = oIdx[0];
    assign out1Idx  = oIdx[1];
    assign out2Idx  = oIdx[2];
    assign out3Idx  = oIdx[3];

endmodule

// File: tb/tb_dist_sorter.sv
// Self-checking bench for dist_sorter: directed sets, random sets checked
// against a stable-sort reference, backpressure, streaming and mid-sort reset.
module tb_dist_sorter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] inaDist = '0, inbDist = '0, incDist = '0, indDist = '0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [15:0] out0Dist, out1Dist, out2Dist, out3Dist;
    logic [1:0]  out0Idx, out1Idx, out2Idx, out3Idx;
    logic        outValid;
    logic        outReady = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [15:0] expD [4];
    int          expI [4];

    always #5 clk = ~clk;

    dist_sorter #(.WIDTH(16), .IDX_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .inaDist(inaDist), .inbDist(inbDist), .incDist(incDist), .indDist(indDist),
        .inValid(inValid), .inReady(inReady),
        .out0Dist(out0Dist), .out1Dist(out1Dist), .out2Dist(out2Dist), .out3Dist(out3Dist),
        .out0Idx(out0Idx), .out1Idx(out1Idx), .out2Idx(out2Idx), .out3Idx(out3Idx),
        .outValid(outValid), .outReady(outReady)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: stable ascending sort of (distance, original index).
    task automatic refSort(input logic [15:0] a, b, c, d);
        logic [15:0] v [4];
        int          id [4];
        logic [15:0] tv;
        int          ti;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) id[i] = i;
        for (int i = 1; i < 4; i++)
            for (int j = i; j > 0; j--)
                if (v[j] < v[j-1]) begin
                    tv = v[j]; v[j] = v[j-1]; v[j-1] = tv;
                    ti = id[j]; id[j] = id[j-1]; id[j-1] = ti;
                end
        for (int i = 0; i < 4; i++) begin
            expD[i] = v[i];
            expI[i] = id[i];
        end
    endtask

    task automatic checkOut(input string tag);
        checkVal({tag, "_d0"}, 32'(out0Dist), 32'(expD[0]));
        checkVal({tag, "_d1"}, 32'(out1Dist), 32'(expD[1]));
        checkVal({tag, "_d2"}, 32'(out2Dist), 32'(expD[2]));
        checkVal({tag, "_d3"}, 32'(out3Dist), 32'(expD[3]));
        checkVal({tag, "_i0"}, 32'(out0Idx), 32'(expI[0]));
        checkVal({tag, "_i1"}, 32'(out1Idx), 32'(expI[1]));
        checkVal({tag, "_i2"}, 32'(out2Idx), 32'(expI[2]));
        checkVal({tag, "_i3"}, 32'(out3Idx), 32'(expI[3]));
    endtask

    task automatic driveSet(input logic [15:0] a, b, c, d);
        inaDist = a; inbDist = b; incDist = c; indDist = d;
    endtask

    // Send one set, check latency and result, optionally hold outReady low.
    task automatic sendSet(input string tag, input logic [15:0] a, b, c, d, input int stall);
        int n;
        refSort(a, b, c, d);
        outReady = 1'b0;
        @(negedge clk);
        driveSet(a, b, c, d);
        inValid = 1'b1;
        checkVal({tag, "_inReady"}, 32'(inReady), 32'd1);
        @(posedge clk);
        #1 inValid = 1'b0;
        n = 0;
        while (!outValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkVal({tag, "_latency"}, n, 32'd5);
        checkOut(tag);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            inValid = 1'($urandom);
            driveSet(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            checkVal({tag, "_holdValid"}, 32'(outValid), 32'd1);
            checkVal({tag, "_holdReady"}, 32'(inReady), 32'd0);
            checkOut({tag, "_hold"});
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkVal({tag, "_postValid"}, 32'(outValid), 32'd0);
        checkVal({tag, "_postReady"}, 32'(inReady), 32'd1);
        outReady = 1'b0;
    endtask

    logic [15:0] sets [4][4];

    initial begin
        int cyc, k, j, lastAcc;

        repeat (3) @(negedge clk);
        checkVal("rst_outValid", 32'(outValid), 32'd0);
        checkVal("rst_d0", 32'(out0Dist), 32'd0);
        checkVal("rst_d3", 32'(out3Dist), 32'd0);
        checkVal("rst_i3", 32'(out3Idx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkVal("rst_inReady", 32'(inReady), 32'd1);

        sendSet("basic", 16'd30, 16'd10, 16'd20, 16'd5, 0);
        sendSet("ties", 16'd7, 16'd7, 16'd7, 16'd7, 0);
        sendSet("wide", 16'hFFFF, 16'h0000, 16'hFFFE, 16'h0001, 0);
        sendSet("bp", 16'd400, 16'd3, 16'd3, 16'd100, 10);

        for (int r = 0; r < 8; r++) begin
            if (r < 4)
                sendSet("rndtie", 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                        16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), 0);
            else
                sendSet("rnd", 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                        int'($urandom_range(0, 3)));
        end

        // Streaming: inValid and outReady held high.
        for (int s = 0; s < 4; s++)
            for (int e = 0; e < 4; e++)
                sets[s][e] = 16'($urandom);
        @(negedge clk);
        driveSet(sets[0][0], sets[0][1], sets[0][2], sets[0][3]);
        inValid = 1'b1;
        outReady = 1'b1;
        cyc = 0; k = 0; j = 0; lastAcc = -1;
        for (int t = 0; t < 40; t++) begin
            if (t > 0) @(negedge clk);
            cyc++;
            if (outValid && j < 4) begin
                refSort(sets[j][0], sets[j][1], sets[j][2], sets[j][3]);
                checkOut("stream");
                j++;
            end
            if (inReady && k < 4) begin
                if (lastAcc >= 0)
                    checkVal("stream_gap", cyc - lastAcc, 32'd6);
                lastAcc = cyc;
                k++;
                @(posedge clk);
                #1;
                if (k < 4) driveSet(sets[k][0], sets[k][1], sets[k][2], sets[k][3]);
                else       inValid = 1'b0;
            end
        end
        checkVal("stream_accepts", k, 32'd4);
        checkVal("stream_results", j, 32'd4);
        inValid = 1'b0;
        outReady = 1'b0;
        @(negedge clk);

        // Reset pulse during phase 2.
        @(negedge clk);
        driveSet(16'd9, 16'd8, 16'd7, 16'd6);
        inValid = 1'b1;
        checkVal("rstmid_inReady", 32'(inReady), 32'd1);
        @(posedge clk);
        #1 inValid = 1'b0;
        outReady = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("rstmid_d0", 32'(out0Dist), 32'd0);
        checkVal("rstmid_d2", 32'(out2Dist), 32'd0);
        checkVal("rstmid_i3", 32'(out3Idx), 32'd0);
        checkVal("rstmid_valid", 32'(outValid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 checkVal("rstmid_ready", 32'(inReady), 32'd1);
        k = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (outValid) k++;
        end
        checkVal("rstmid_noValid", k, 32'd0);
        sendSet("after_rst", 16'd50, 16'd2, 16'd50, 16'd1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
